// File: rtl/scanline_tile_renderer_pkg.sv
// video_types: shared types and helpers for the tile renderer.
// Holds the tile size, render FSM states, layer ids, the palette lookup
// and the tile-map address formula.
package video_types;

  localparam int TILE_DIM = 8;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_MAP,
    FETCH_TILE,
    EMIT,
    DONE
  } render_state_t;

  typedef enum logic {
    LAYER_BG  = 1'b0,
    LAYER_WIN = 1'b1
  } layer_t;

  // Map a colour index through a packed palette of color_bits-wide entries.
  function automatic int unsigned paletteLookup(input logic [31:0] palette,
                                                input int unsigned idx,
                                                input int unsigned color_bits);
    logic [31:0] v;
    v = palette >> (idx * color_bits);
    return v & ((32'd1 << color_bits) - 32'd1);
  endfunction

  // Word address of a map entry; each layer owns one map_dim x map_dim map.
  function automatic int unsigned tileMapAddr(input layer_t layer,
                                              input int unsigned row,
                                              input int unsigned col,
                                              input int unsigned map_dim);
    int unsigned base;
    base = (layer == LAYER_WIN) ? map_dim * map_dim : 32'd0;
    return base + row * map_dim + col;
  endfunction

endpackage

// File: rtl/scanline_tile_renderer_shifter.sv
// tile_row_shifter: holds one fetched tile row and presents its colour
// indices left to right, advancing one index per accepted pixel.
module tile_row_shifter
  import video_types::*;
#(
  parameter int COLOR_BITS = 2
) (
  input  logic                           clk,
  input  logic                           i_reset,
  input  logic                           i_load,
  input  logic [TILE_DIM*COLOR_BITS-1:0] i_row,
  input  logic [$clog2(TILE_DIM)-1:0]    i_fine,
  input  logic                           i_shift,
  output logic [COLOR_BITS-1:0]          o_index,
  output logic                           o_last,
  output logic                           o_empty
);

  localparam int ROW_W = TILE_DIM * COLOR_BITS;
  localparam int CNT_W = $clog2(TILE_DIM + 1);

  logic [ROW_W-1:0] r_row;
  logic [CNT_W-1:0] r_count;

  // Load drops the leading fine-scroll pixels; each shift drops the leftmost index.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_row   <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_row   <= i_row >> (int'(i_fine) * COLOR_BITS);
      r_count <= CNT_W'(TILE_DIM - int'(i_fine));
    end else if (i_shift && (r_count != '0)) begin
      r_row   <= r_row >> COLOR_BITS;
      r_count <= r_count - 1'b1;
    end
  end

  assign o_index = r_row[COLOR_BITS-1:0];
  assign o_last  = (r_count == CNT_W'(1));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/scanline_tile_renderer.sv
// scanline_tile_renderer: renders one LCD line per start pulse from the
// background (and optionally window) tile maps over a req/ack memory port,
// streaming palette-mapped pixels over valid/ready.
// Build option: define SCANLINE_WINDOW_EN to include the window layer;
// without it the window inputs are ignored and the map layer term is 0.
module scanline_tile_renderer
  import video_types::*;
#(
  parameter int LCD_WIDTH  = 160,
  parameter int LCD_HEIGHT = 144,
  parameter int MAP_DIM    = 32,
  parameter int TILE_COUNT = 384,
  parameter int COLOR_BITS = 2,
  parameter int ADDR_W     = ($clog2(2*MAP_DIM*MAP_DIM) > $clog2(TILE_COUNT*TILE_DIM)) ?
                             $clog2(2*MAP_DIM*MAP_DIM) : $clog2(TILE_COUNT*TILE_DIM)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [7:0]                            line,
  input  logic [7:0]                            scroll_x,
  input  logic [7:0]                            scroll_y,
  input  logic [7:0]                            win_x,
  input  logic [7:0]                            win_y,
  input  logic                                  bg_enable,
  input  logic                                  win_enable,
  input  logic [(COLOR_BITS<<COLOR_BITS)-1:0]   palette,
  output logic                                  mem_req,
  output logic                                  mem_is_tile,
  output logic [ADDR_W-1:0]                     mem_addr,
  input  logic                                  mem_ack,
  input  logic [TILE_DIM*COLOR_BITS-1:0]        mem_rdata,
  output logic                                  pix_valid,
  input  logic                                  pix_ready,
  output logic [$clog2(LCD_WIDTH)-1:0]          pix_x,
  output logic [COLOR_BITS-1:0]                 pix_color,
  output logic                                  busy,
  output logic                                  line_done
);

  localparam int XW      = $clog2(LCD_WIDTH + 1);
  localparam int PXW     = $clog2(LCD_WIDTH);
  localparam int PAL_W   = COLOR_BITS << COLOR_BITS;
  localparam int TIDX_W  = $clog2(TILE_COUNT);
  localparam int FINE_W  = $clog2(TILE_DIM);
  localparam int BG_SPAN = MAP_DIM * TILE_DIM;

  render_state_t          r_state;
  logic [XW-1:0]          r_x;
  logic [7:0]             r_line, r_scroll_x, r_scroll_y;
  logic                   r_bg_en;
  logic [PAL_W-1:0]       r_palette;
  layer_t                 r_layer;
  logic [FINE_W-1:0]      r_tile_row, r_fine;
  logic                   r_mem_req, r_mem_is_tile;
  logic [ADDR_W-1:0]      r_mem_addr;
  logic                   r_pix_valid;
  logic [PXW-1:0]         r_pix_x;
  logic                   r_busy, r_line_done;
`ifdef SCANLINE_WINDOW_EN
  logic [7:0]             r_win_x, r_win_y;
  logic                   r_win_en;
`endif

  int                     w_fx, w_fline, w_fscx, w_fscy;
  int                     w_bx, w_by, w_col, w_row, w_trow, w_fine;
  int                     w_entry;
  logic                   w_f_win;
  layer_t                 w_f_layer;
  logic [ADDR_W-1:0]      w_map_addr, w_tile_addr;
  logic [XW-1:0]          w_x_inc;
  logic                   w_xfer, w_win_switch;
  logic [COLOR_BITS-1:0]  w_sh_index, w_idx;
  logic                   w_sh_last, w_sh_empty;
  logic [31:0]            w_pal_val;

  // Fetch coordinates come from the live inputs at start, latched copies afterwards.
  always_comb begin
    if (r_state == IDLE) begin
      w_fx    = 0;
      w_fline = int'(line);
      w_fscx  = int'(scroll_x);
      w_fscy  = int'(scroll_y);
    end else begin
      w_fx    = int'(r_x) + 1;
      w_fline = int'(r_line);
      w_fscx  = int'(r_scroll_x);
      w_fscy  = int'(r_scroll_y);
    end
  end

`ifdef SCANLINE_WINDOW_EN
  int   w_fwx, w_fwy;
  logic w_fwen;

  // Window is active once the fetch column has reached the window origin.
  always_comb begin
    if (r_state == IDLE) begin
      w_fwx  = int'(win_x);
      w_fwy  = int'(win_y);
      w_fwen = win_enable;
    end else begin
      w_fwx  = int'(r_win_x);
      w_fwy  = int'(r_win_y);
      w_fwen = r_win_en;
    end
    w_f_win = w_fwen && (w_fline >= w_fwy) && (w_fx >= w_fwx);
  end
`else
  assign w_f_win = 1'b0;
`endif

  // Map coordinates, tile row and fine offset of the tile about to be fetched.
  always_comb begin
    w_bx      = (w_fscx + w_fx) % BG_SPAN;
    w_by      = (w_fscy + w_fline) % BG_SPAN;
    w_f_layer = LAYER_BG;
    w_col     = w_bx / TILE_DIM;
    w_row     = w_by / TILE_DIM;
    w_trow    = w_by % TILE_DIM;
    w_fine    = w_bx % TILE_DIM;
`ifdef SCANLINE_WINDOW_EN
    if (w_f_win) begin
      w_f_layer = LAYER_WIN;
      w_col     = (w_fx - w_fwx) / TILE_DIM;
      w_row     = (w_fline - w_fwy) / TILE_DIM;
      w_trow    = (w_fline - w_fwy) % TILE_DIM;
      w_fine    = 0;
    end
`endif
    w_map_addr = ADDR_W'(tileMapAddr(w_f_layer, w_row, w_col, MAP_DIM));
  end

  // Tile-row address from the returned map entry; out-of-range entries use tile 0.
  always_comb begin
    w_entry = int'(mem_rdata[TIDX_W-1:0]);
    if (w_entry >= TILE_COUNT) w_entry = 0;
    w_tile_addr = ADDR_W'(w_entry * TILE_DIM + int'(r_tile_row));
  end

  assign w_x_inc      = r_x + 1'b1;
  assign w_xfer       = (r_state == EMIT) && r_pix_valid && pix_ready && !w_sh_empty;
  assign w_win_switch = (r_layer == LAYER_BG) && w_f_win;

  tile_row_shifter #(
    .COLOR_BITS (COLOR_BITS)
  ) u_shifter (
    .clk     (clk),
    .i_reset (reset),
    .i_load  ((r_state == FETCH_TILE) && mem_ack),
    .i_row   (mem_rdata),
    .i_fine  (r_fine),
    .i_shift (w_xfer),
    .o_index (w_sh_index),
    .o_last  (w_sh_last),
    .o_empty (w_sh_empty)
  );

  // A disabled background shows index 0; the window ignores bg_enable.
  always_comb begin
    w_idx     = ((r_layer == LAYER_BG) && !r_bg_en) ? '0 : w_sh_index;
    w_pal_val = paletteLookup(32'(r_palette), 32'(w_idx), COLOR_BITS);
  end

  // Render FSM: start latch, map fetch, tile fetch, pixel emit, line done.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_x           <= '0;
      r_line        <= '0;
      r_scroll_x    <= '0;
      r_scroll_y    <= '0;
      r_bg_en       <= 1'b0;
      r_palette     <= '0;
      r_layer       <= LAYER_BG;
      r_tile_row    <= '0;
      r_fine        <= '0;
      r_mem_req     <= 1'b0;
      r_mem_is_tile <= 1'b0;
      r_mem_addr    <= '0;
      r_pix_valid   <= 1'b0;
      r_pix_x       <= '0;
      r_busy        <= 1'b0;
      r_line_done   <= 1'b0;
`ifdef SCANLINE_WINDOW_EN
      r_win_x       <= '0;
      r_win_y       <= '0;
      r_win_en      <= 1'b0;
`endif
    end else begin
      r_line_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && (int'(line) < LCD_HEIGHT)) begin
            r_line        <= line;
            r_scroll_x    <= scroll_x;
            r_scroll_y    <= scroll_y;
            r_bg_en       <= bg_enable;
            r_palette     <= palette;
`ifdef SCANLINE_WINDOW_EN
            r_win_x       <= win_x;
            r_win_y       <= win_y;
            r_win_en      <= win_enable;
`endif
            r_x           <= '0;
            r_pix_x       <= '0;
            r_busy        <= 1'b1;
            r_mem_req     <= 1'b1;
            r_mem_is_tile <= 1'b0;
            r_mem_addr    <= w_map_addr;
            r_layer       <= w_f_layer;
            r_tile_row    <= FINE_W'(w_trow);
            r_fine        <= FINE_W'(w_fine);
            r_state       <= FETCH_MAP;
          end
        end
        FETCH_MAP: begin
          if (mem_ack) begin
            r_mem_is_tile <= 1'b1;
            r_mem_addr    <= w_tile_addr;
            r_state       <= FETCH_TILE;
          end
        end
        FETCH_TILE: begin
          if (mem_ack) begin
            r_mem_req     <= 1'b0;
            r_mem_is_tile <= 1'b0;
            r_pix_valid   <= 1'b1;
            r_state       <= EMIT;
          end
        end
        EMIT: begin
          if (w_xfer) begin
            r_x <= w_x_inc;
            if (int'(w_x_inc) == LCD_WIDTH) begin
              r_pix_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_line_done <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_pix_x <= PXW'(w_x_inc);
              if (w_sh_last || w_win_switch) begin
                r_pix_valid   <= 1'b0;
                r_mem_req     <= 1'b1;
                r_mem_is_tile <= 1'b0;
                r_mem_addr    <= w_map_addr;
                r_layer       <= w_f_layer;
                r_tile_row    <= FINE_W'(w_trow);
                r_fine        <= FINE_W'(w_fine);
                r_state       <= FETCH_MAP;
              end
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_req     = r_mem_req;
  assign mem_is_tile = r_mem_is_tile;
  assign mem_addr    = r_mem_addr;
  assign pix_valid   = r_pix_valid;
  assign pix_x       = r_pix_x;
  assign pix_color   = w_pal_val[COLOR_BITS-1:0];
  assign busy        = r_busy;
  assign line_done   = r_line_done;

endmodule

// File: tb/tb_scanline_tile_renderer.sv
// Scoreboard bench for scanline_tile_renderer: a per-pixel reference model
// fills an expectation queue at each start; a monitor checks every
// presented pixel against the queue head and pops on acceptance.
`timescale 1ns/1ps
module tb_scanline_tile_renderer;

  localparam int W = 160;

`ifdef SCANLINE_WINDOW_EN
  localparam bit WIN_EN = 1'b1;
`else
  localparam bit WIN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, start;
  logic [7:0]  line, scroll_x, scroll_y, win_x, win_y;
  logic        bg_enable, win_enable;
  logic [7:0]  palette;
  logic        mem_req, mem_is_tile;
  logic [11:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        pix_valid, pix_ready;
  logic [7:0]  pix_x;
  logic [1:0]  pix_color;
  logic        busy, line_done;

  always #5 clk = ~clk;

  scanline_tile_renderer dut (
    .clk(clk), .reset(reset), .start(start), .line(line),
    .scroll_x(scroll_x), .scroll_y(scroll_y), .win_x(win_x), .win_y(win_y),
    .bg_enable(bg_enable), .win_enable(win_enable), .palette(palette),
    .mem_req(mem_req), .mem_is_tile(mem_is_tile), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x),
    .pix_color(pix_color), .busy(busy), .line_done(line_done)
  );

  logic [15:0] map_mem  [0:2047];
  logic [15:0] tile_mem [0:3071];

  typedef struct { int x; int color; } pix_t;
  pix_t exp_q[$];
  int   cap [0:W-1];

  int checks = 0, failures = 0;
  int done_cnt = 0;
  int mem_lat = 1, mem_cnt = 0;
  int ready_mode = 0;

  // Reference: colour of screen column x from the layer/scroll rules.
  function automatic int model_pixel(input int x, input int ln, input int scx, input int scy,
                                     input int wx, input int wy, input bit bgen, input bit winen,
                                     input int pal, output int maddr);
    bit win;
    int tx, ty, ent, p, idx;
    logic [15:0] row;
    win = WIN_EN && winen && (ln >= wy) && (x >= wx);
    if (win) begin
      tx = x - wx; ty = ln - wy;
      maddr = 1024 + (ty / 8) * 32 + tx / 8;
    end else begin
      tx = (scx + x) % 256; ty = (scy + ln) % 256;
      maddr = (ty / 8) * 32 + tx / 8;
    end
    ent = int'(map_mem[maddr]) % 512;
    if (ent >= 384) ent = 0;
    row = tile_mem[ent * 8 + ty % 8];
    p = tx % 8;
    idx = int'((row >> (2 * p)) & 16'h3);
    if (!win && !bgen) idx = 0;
    return (pal >> (2 * idx)) & 3;
  endfunction

  // Memory: acknowledges each request after mem_lat cycles.
  always @(negedge clk) begin
    if (reset) begin
      mem_ack = 1'b0; mem_cnt = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0; mem_cnt = 0;
      mem_rdata = 16'($urandom);
    end else if (mem_req) begin
      if (mem_cnt >= mem_lat - 1) begin
        mem_ack = 1'b1;
        if (mem_is_tile) mem_rdata = tile_mem[mem_addr];
        else mem_rdata = (mem_addr < 12'd2048) ? map_mem[mem_addr[10:0]] : 16'h0;
      end else begin
        mem_cnt++;
      end
    end else begin
      mem_cnt = 0;
    end
  end

  // Sink readiness pattern.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: pix_ready = 1'b1;
      1: pix_ready = ~pix_ready;
      default: pix_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: every presented pixel must match the queue head, held until accepted.
  always @(negedge clk) begin
    if (!reset) begin
      if (line_done) done_cnt++;
      if (pix_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL pixel_extra x=%0d color=%0d required no pixel", pix_x, pix_color);
        end else begin
          if (int'(pix_x) != exp_q[0].x || int'(pix_color) != exp_q[0].color) begin
            failures++;
            $display("FAIL pixel got x=%0d color=%0d required x=%0d color=%0d",
                     pix_x, pix_color, exp_q[0].x, exp_q[0].color);
          end
          if (pix_ready) begin
            if (int'(pix_x) < W) cap[pix_x] = int'(pix_color);
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic start_line(input int ln, input int scx, input int scy, input int wx, input int wy,
                            input bit bgen, input bit winen, input int pal, input string tag);
    int m, m0;
    pix_t e;
    m0 = 0;
    for (int x = 0; x < W; x++) begin
      e.x = x;
      e.color = model_pixel(x, ln, scx, scy, wx, wy, bgen, winen, pal, m);
      if (x == 0) m0 = m;
      exp_q.push_back(e);
      cap[x] = -1;
    end
    @(negedge clk);
    line = 8'(ln); scroll_x = 8'(scx); scroll_y = 8'(scy);
    win_x = 8'(wx); win_y = 8'(wy); bg_enable = bgen; win_enable = winen;
    palette = 8'(pal); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scroll_x = 8'($urandom); scroll_y = 8'($urandom); palette = 8'($urandom);
    win_x = 8'($urandom); bg_enable = 1'($urandom_range(0, 1)); line = 8'($urandom);
    checks++;
    if (mem_req !== 1'b1 || mem_is_tile !== 1'b0 || int'(mem_addr) != m0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL %s first_fetch req=%0b tile=%0b addr=%0d busy=%0b required req=1 tile=0 addr=%0d busy=1",
               tag, mem_req, mem_is_tile, mem_addr, busy, m0);
    end
  endtask

  task automatic finish_line(input string tag);
    int d0;
    bit got;
    d0 = done_cnt;
    got = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (done_cnt != d0) begin got = 1'b1; break; end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s line_done_timeout got none required one pulse", tag);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0 || done_cnt != d0 + 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s line_end left=%0d done_pulses=%0d busy=%0b required left=0 done_pulses=1 busy=0",
               tag, exp_q.size(), done_cnt - d0, busy);
    end
    exp_q.delete();
    $display("line %s complete checks=%0d", tag, checks);
  endtask

  task automatic render(input int ln, input int scx, input int scy, input int wx, input int wy,
                        input bit bgen, input bit winen, input int pal, input string tag);
    start_line(ln, scx, scy, wx, wy, bgen, winen, pal, tag);
    finish_line(tag);
  endtask

  initial begin
    bit found;
    int want [0:7];
    for (int i = 0; i < 2048; i++) map_mem[i] = 16'($urandom);
    for (int i = 0; i < 3072; i++) tile_mem[i] = 16'($urandom);
    for (int c = 0; c < 4; c++) map_mem[c] = {7'h7f, 9'(c + 1)};
    tile_mem[8]  = 16'hFF00;
    for (int r = 0; r < 8; r++) tile_mem[16 + r] = 16'hE4E4;
    for (int r = 0; r < 8; r++) tile_mem[24 + r] = (r == 3 || r == 4) ? 16'hFFFF : 16'h03C0;
    want = '{3, 3, 3, 3, 0, 0, 0, 0};

    reset = 1'b1; start = 1'b0; line = '0; scroll_x = '0; scroll_y = '0;
    win_x = '0; win_y = '0; bg_enable = 1'b0; win_enable = 1'b0; palette = '0;
    mem_ack = 1'b0; mem_rdata = '0; pix_ready = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_req, mem_addr, pix_valid, pix_x, pix_color, busy, line_done} !== '0) begin
      failures++;
      $display("FAIL reset_outputs req=%0b addr=%0d valid=%0b x=%0d color=%0d busy=%0b done=%0b required all 0",
               mem_req, mem_addr, pix_valid, pix_x, pix_color, busy, line_done);
    end
    reset = 1'b0;
    @(negedge clk);

    // Default line with known checkerboard in tile 1.
    render(0, 0, 0, 0, 0, 1'b1, 1'b0, 8'h1b, "defaults");
    for (int x = 0; x < 8; x++) begin
      checks++;
      if (cap[x] != want[x]) begin
        failures++;
        $display("FAIL defaults_px%0d got=%0d required=%0d", x, cap[x], want[x]);
      end
    end

    render(0, 252, 0, 0, 0, 1'b1, 1'b0, 8'h1b, "hwrap");
    render(10, 0, 250, 0, 0, 1'b1, 1'b0, 8'h1b, "vwrap");
    render(5, 3, 7, 20, 0, 1'b1, 1'b1, 8'h1b, "window");

    ready_mode = 1; mem_lat = 3;
    render(0, 0, 0, 0, 0, 1'b1, 1'b0, 8'h1b, "stalled");
    ready_mode = 0; mem_lat = 1;

    // Out-of-range line must be ignored.
    @(negedge clk);
    line = 8'd144; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || mem_req !== 1'b0 || pix_valid !== 1'b0) begin
      failures++;
      $display("FAIL reject_line busy=%0b req=%0b valid=%0b required 0 0 0", busy, mem_req, pix_valid);
    end

    // Reset partway through a line.
    start_line(5, 0, 0, 0, 0, 1'b1, 1'b0, 8'h1b, "abort");
    found = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (pix_valid && pix_x == 8'd50) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL abort_reach_x50 got none required pixel x=50");
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (mem_req !== 1'b0 || pix_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_reset req=%0b valid=%0b busy=%0b required 0 0 0", mem_req, pix_valid, busy);
    end
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    render(7, 0, 0, 0, 0, 1'b1, 1'b0, 8'h1b, "after_abort");

    // Randomized lines, latencies and sink patterns.
    for (int n = 0; n < 8; n++) begin
      mem_lat = $urandom_range(1, 3);
      ready_mode = $urandom_range(0, 2);
      render($urandom_range(0, 143), $urandom_range(0, 255), $urandom_range(0, 255),
             $urandom_range(0, 159), $urandom_range(0, 143),
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             $urandom_range(0, 255), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scanline_tile_renderer.md
Name: scanline_tile_renderer

Overview:
- Parametrised successor to the fixed 160x144 whizgraphics background path.
- Renders one LCD scanline per `start` pulse:
  - walks the background tile map with wrap-around scrolling;
  - switches to the window layer mid-line;
  - fetches map entries and tile rows over a shared req/ack memory port;
  - emits palette-mapped pixels over a valid/ready stream to the LCD line buffer.
- Sits between VRAM (tiles, vramBackground1/2) and the LCD frame store.

Parameters:
- LCD_WIDTH, 160, visible pixels per line.
- LCD_HEIGHT, 144, visible lines; `line` >= LCD_HEIGHT is rejected.
- MAP_DIM, 32, tile map is MAP_DIM x MAP_DIM entries.
- TILE_COUNT, 384, tiles addressable by a map entry.
- COLOR_BITS, 2, bits per pixel; tile row = TILE_DIM*COLOR_BITS bits.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  pulse: render `line`
- line  in  8  line number
- scroll_x, scroll_y  in  8 each  background scroll
- win_x, win_y  in  8 each  window origin in screen pixels
- bg_enable, win_enable  in  1 each  layer enables
- palette  in  COLOR_BITS<<COLOR_BITS  index i maps to palette[i*COLOR_BITS +: COLOR_BITS]
- mem_req  out  1  memory read request
- mem_is_tile  out  1  0 = map read, 1 = tile-row read
- mem_addr  out  ADDR_W  map: layer*MAP_DIM^2 + row*MAP_DIM + col; tile: tile*TILE_DIM + row
- mem_ack  in  1  one-cycle read completion
- mem_rdata  in  TILE_DIM*COLOR_BITS  read data; map reads use low clog2(TILE_COUNT) bits
- pix_valid  out  1  pixel valid
- pix_ready  in  1  sink ready
- pix_x  out  clog2(LCD_WIDTH)  pixel column
- pix_color  out  COLOR_BITS  palette-mapped colour
- busy  out  1  line in progress
- line_done  out  1  one-cycle pulse after the last pixel is accepted

Behaviour:
- Reset: state IDLE; all outputs 0 (mem_req, mem_addr, pix_valid, pix_x, pix_color, busy, line_done). Reset mid-line aborts immediately; no further pixel is emitted.
- FSM states: IDLE, FETCH_MAP, FETCH_TILE, EMIT, DONE.
- IDLE:
  - `start` with line < LCD_HEIGHT → FETCH_MAP, busy=1; x=0.
  - Latch scroll_x/scroll_y, win_x/win_y, both enables, palette and line at start. Changes mid-line have no effect.
  - Otherwise `start` is ignored. `start` is also ignored while busy.
- Layer select at each fetch: window if win_enable and line >= win_y and x >= win_x; otherwise background.
- Background coordinates: bx = (scroll_x + x) mod (MAP_DIM*TILE_DIM), by = (scroll_y + line) mod (MAP_DIM*TILE_DIM).
  - Map column = bx/TILE_DIM; map row = by/TILE_DIM; tile row = by mod TILE_DIM.
  - First tile starts at fine offset bx mod TILE_DIM.
- Window coordinates: wx = x - win_x, wy = line - win_y. Fine offset is always 0.
- Memory handshake:
  - mem_req, mem_is_tile and mem_addr are registered and held stable until mem_ack.
  - mem_rdata is sampled on the mem_ack cycle. mem_ack while mem_req=0 is ignored.
  - Map entries >= TILE_COUNT are clamped to tile 0.
- FETCH_MAP --ack--> FETCH_TILE --ack--> EMIT.
- EMIT:
  - Pixel p of the row is at mem_rdata[p*COLOR_BITS +: COLOR_BITS]; p=0 is leftmost.
  - Pixel output is pix_color = palette lookup of that index.
  - If bg_enable=0 and the window is not active, the index is 0.
  - pix_valid is held with pix_x/pix_color stable until pix_ready; a transfer occurs on valid&ready and increments x.
  - EMIT → FETCH_MAP when the row is exhausted, or on the same transfer where x reaches win_x (window switch; remaining background pixels are discarded).
  - EMIT → DONE when x reaches LCD_WIDTH.
- DONE: line_done=1 for one cycle, busy=0, → IDLE.
- Throughput: with mem_ack one cycle after req and pix_ready=1, a full tile takes 2 fetch handshakes + TILE_DIM emit cycles.

Optional Feature:
- Macro: SCANLINE_WINDOW_EN.
- Defined: window layer as above.
- Undefined:
  - window logic is removed; win_x, win_y and win_enable are ignored (ports remain);
  - mem_addr layer term is always 0.

Decomposition:
- Shared package video_types gets:
  - TILE_DIM = 8;
  - the render state enum;
  - the layer_t enum (LAYER_BG, LAYER_WIN);
  - functions paletteLookup() and tileMapAddr().
- One sub-module, tile_row_shifter: loads a row plus fine offset and shifts out one index per accepted pixel, with an empty flag.

Test Plan:
- All defaults, map[0][0..3]=1..4 (checkerboard/cross/gradients), scroll 0, line 0, palette 8'h1b, pix_ready=1.
  → Pixels x=0..7 are colours 3,3,3,3,0,0,0,0 (checkerboard row 0, inverted by 8'h1b).
  → 160 pixels, then one line_done.
- scroll_x=252, line 0 → first map read col=31; first 4 pixels come from map col 31; x=4 uses col 0 (horizontal wrap).
- scroll_y=250, line 10 → map row 0, tile row 4 (vertical wrap).
- win_enable=1, win_x=20, win_y=0 → pixels x<20 are background; x=20 triggers a layer-1 map read at col 0; window tile-row pixel 0 appears at x=20.
- pix_ready toggled every other cycle plus 3-cycle mem_ack latency → same 160-pixel sequence; outputs held stable while stalled.
- reset asserted at x=50 → next cycle mem_req=0, pix_valid=0, busy=0; a following start renders cleanly from x=0.
